enemy_spawn_scheduler: RTL and testbench



---
 rtl/game_pkg.sv | 60 ++++++
 rtl/spawn_lfsr.sv | 42 ++++
 rtl/enemy_spawn_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_enemy_spawn_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants and helpers.
// Screen timing for the 1024x768 visible area, enemy sprite geometry,
// the enemy slot pool size, the spawn scheduler FSM states, and the LFSR
// and spawn-position helpers used by the scheduler and its LFSR.
package game_pkg;

  // Horizontal timing, in pixels.
  localparam logic [10:0] HOR_ACTIVE_VEDIO  = 11'd1024;
  localparam logic [10:0] HOR_FRONT_PORCH   = 11'd24;
  localparam logic [10:0] HOR_SYNC          = 11'd136;
  localparam logic [10:0] HOR_BACK_PORCH    = 11'd160;
  // Vertical timing, in lines.
  localparam logic [10:0] VER_ACTIVE_VEDIO  = 11'd768;
  localparam logic [10:0] VER_FRONT_PORCH   = 11'd3;
  localparam logic [10:0] VER_SYNC          = 11'd6;
  localparam logic [10:0] VER_BACK_PORCH    = 11'd29;

  // Enemy sprite half extents.
  localparam logic [10:0] ENEMY_PLANE_HALF_WIDTH  = 11'd64;
  localparam logic [10:0] ENEMY_PLANE_HALF_HEIGHT = 11'd64;

  // Number of concurrently active enemies.
  localparam int SLOTS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SCAN  = 2'd2,
    ST_SPAWN = 2'd3
  } spawn_state_e;

  // One step of the right-shifting Galois LFSR (taps 16'hB400).
  function automatic logic [15:0] lfsr_step(input logic [15:0] r);
    logic [15:0] n;
    if (r[0]) begin
      n = {1'b0, r[15:1]} ^ 16'hB400;
    end else begin
      n = {1'b0, r[15:1]};
    end
    return n;
  endfunction

  // Enemy center x: low 10 LFSR bits clamped so the sprite stays on screen.
  function automatic logic [10:0] spawn_x_from_lfsr(input logic [15:0] r,
                                                    input logic [10:0] lo,
                                                    input logic [10:0] hi);
    logic [10:0] v;
    logic [10:0] x;
    v = {1'b0, r[9:0]};
    if (v < lo) begin
      x = lo;
    end else if (v > hi) begin
      x = hi;
    end else begin
      x = v;
    end
    return x;
  endfunction

endpackage

// File: rtl/spawn_lfsr.sv
// 16-bit Galois LFSR that steps once per cycle with advance high.
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-high reset, loads SEED
//   advance in   step the register this cycle
//   value   out  current LFSR state
module spawn_lfsr
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next state: one step when advancing, otherwise hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) begin
      lfsr_d = lfsr_step(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/enemy_spawn_scheduler.sv
// Schedules enemies into a fixed pool of slots.
// A frame counter paced by vs_neg raises spawn_due every SPAWN_PERIOD frames;
// the FSM then scans slots round-robin from rr_ptr and spawns into the first
// free one at a pseudo-random x. Hit reports retire slots and count kills.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   vs_neg            one-cycle per-frame strobe
//   game_en           scheduling enable; low clears slots and pending spawn
//   hit_valid/hit_idx hit report from collision logic
//   alive             per-slot occupied flags
//   spawn_pulse       one-cycle spawn command with spawn_idx / spawn_x
//   kill_count        saturating count of accepted hits
module enemy_spawn_scheduler
  import game_pkg::*;
#(
  parameter int          SLOTS                  = game_pkg::SLOTS,
  parameter logic [10:0] SPAWN_PERIOD           = 11'd60,
  parameter logic [10:0] HOR_ACTIVE_VEDIO       = game_pkg::HOR_ACTIVE_VEDIO,
  parameter logic [10:0] ENEMY_PLANE_HALF_WIDTH = game_pkg::ENEMY_PLANE_HALF_WIDTH,
  parameter logic [15:0] LFSR_SEED              = 16'hACE1,
  localparam int         IW                     = $clog2(SLOTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vs_neg,
  input  logic             game_en,
  input  logic             hit_valid,
  input  logic [IW-1:0]    hit_idx,
  output logic [SLOTS-1:0] alive,
  output logic             spawn_pulse,
  output logic [IW-1:0]    spawn_idx,
  output logic [10:0]      spawn_x,
  output logic [15:0]      kill_count
);

  localparam logic [10:0]   X_MIN     = ENEMY_PLANE_HALF_WIDTH;
  localparam logic [10:0]   X_MAX     = HOR_ACTIVE_VEDIO - 11'd1 - ENEMY_PLANE_HALF_WIDTH;
  localparam logic [IW-1:0] SCAN_LAST = IW'(SLOTS - 1);
  localparam logic [IW-1:0] ONE_IDX   = IW'(1);

  spawn_state_e     state_q;
  logic [10:0]      frame_cnt_q;
  logic             spawn_due_q;
  logic [IW-1:0]    rr_ptr_q;
  logic [IW-1:0]    scan_cnt_q;
  logic [SLOTS-1:0] alive_q;
  logic [SLOTS-1:0] alive_d;
  logic [15:0]      kill_q;
  logic [15:0]      kill_d;
  logic             spawn_pulse_q;
  logic [IW-1:0]    spawn_idx_q;
  logic [10:0]      spawn_x_q;
  logic [15:0]      lfsr_s;
  logic             frame_wrap_s;
  logic             spawn_commit_s;
  logic             hit_accept_s;

  // The spawn completes at the end of the SPAWN cycle unless the game stops.
  assign spawn_commit_s = (state_q == ST_SPAWN) && game_en;
  assign frame_wrap_s   = game_en && vs_neg && (frame_cnt_q == SPAWN_PERIOD - 11'd1);

  spawn_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (spawn_commit_s),
    .value   (lfsr_s)
  );

  // Frame counter: counts vs_neg strobes while the game runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= 11'd0;
    end else if (!game_en) begin
      frame_cnt_q <= 11'd0;
    end else if (vs_neg) begin
      frame_cnt_q <= frame_wrap_s ? 11'd0 : frame_cnt_q + 11'd1;
    end
  end

  // Slot occupancy and kill count; a slot being spawned is still dead, so a
  // hit aimed at it is dropped and the spawn wins.
  always_comb begin
    alive_d      = alive_q;
    kill_d       = kill_q;
    hit_accept_s = hit_valid && alive_q[hit_idx];
    if (!game_en) begin
      alive_d = {SLOTS{1'b0}};
    end else begin
      if (hit_accept_s) begin
        alive_d[hit_idx] = 1'b0;
        if (kill_q != 16'hFFFF) begin
          kill_d = kill_q + 16'd1;
        end else begin
          kill_d = kill_q;
        end
      end else begin
        kill_d = kill_q;
      end
      if (spawn_commit_s) begin
        alive_d[rr_ptr_q] = 1'b1;
      end else begin
        alive_d[rr_ptr_q] = alive_d[rr_ptr_q];
      end
    end
  end

  // Occupancy and kill registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive_q <= {SLOTS{1'b0}};
      kill_q  <= 16'd0;
    end else begin
      alive_q <= alive_d;
      kill_q  <= kill_d;
    end
  end

  // Scheduler FSM with registered spawn outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      spawn_due_q   <= 1'b0;
      rr_ptr_q      <= {IW{1'b0}};
      scan_cnt_q    <= {IW{1'b0}};
      spawn_pulse_q <= 1'b0;
      spawn_idx_q   <= {IW{1'b0}};
      spawn_x_q     <= 11'd0;
    end else begin
      spawn_pulse_q <= 1'b0;
      if (!game_en) begin
        // rr_ptr is deliberately kept so the next game continues the rotation.
        state_q     <= ST_IDLE;
        spawn_due_q <= 1'b0;
        scan_cnt_q  <= {IW{1'b0}};
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_WAIT;
          end
          ST_WAIT: begin
            if (spawn_due_q) begin
              spawn_due_q <= 1'b0;
              scan_cnt_q  <= {IW{1'b0}};
              state_q     <= ST_SCAN;
            end
          end
          ST_SCAN: begin
            if (!alive_q[rr_ptr_q]) begin
              state_q       <= ST_SPAWN;
              spawn_pulse_q <= 1'b1;
              spawn_idx_q   <= rr_ptr_q;
              spawn_x_q     <= spawn_x_from_lfsr(lfsr_s, X_MIN, X_MAX);
            end else begin
              // After SLOTS occupied probes rr_ptr is back where it started.
              rr_ptr_q   <= rr_ptr_q + ONE_IDX;
              scan_cnt_q <= scan_cnt_q + ONE_IDX;
              if (scan_cnt_q == SCAN_LAST) begin
                state_q <= ST_WAIT;
              end
            end
          end
          ST_SPAWN: begin
            rr_ptr_q <= rr_ptr_q + ONE_IDX;
            state_q  <= ST_WAIT;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
        // Placed after the FSM so a new frame wrap is never lost to a clear.
        if (frame_wrap_s) begin
          spawn_due_q <= 1'b1;
        end
      end
    end
  end

  assign alive       = alive_q;
  assign spawn_pulse = spawn_pulse_q;
  assign spawn_idx   = spawn_idx_q;
  assign spawn_x     = spawn_x_q;
  assign kill_count  = kill_q;

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Self-checking bench for enemy_spawn_scheduler: directed sequences, a
// randomized phase against a slot-pool reference model, and a clamp table.
module tb_enemy_spawn_scheduler;
  import game_pkg::*;

  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        vs_neg;
  logic        game_en;
  logic        hit_valid;
  logic [1:0]  hit_idx;
  logic [3:0]  alive;
  logic        spawn_pulse;
  logic [1:0]  spawn_idx;
  logic [10:0] spawn_x;
  logic [15:0] kill_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  enemy_spawn_scheduler u_dut (
    .clk         (clk),
    .rst         (rst),
    .vs_neg      (vs_neg),
    .game_en     (game_en),
    .hit_valid   (hit_valid),
    .hit_idx     (hit_idx),
    .alive       (alive),
    .spawn_pulse (spawn_pulse),
    .spawn_idx   (spawn_idx),
    .spawn_x     (spawn_x),
    .kill_count  (kill_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_lfsr_next(input logic [15:0] r);
    int u;
    u = int'(r) / 2;
    if (r[0]) u = u ^ 32'h0000B400;
    return u[15:0];
  endfunction

  function automatic int ref_x(input logic [15:0] r);
    int v;
    v = int'(r) % 1024;
    if (v < 64) return 64;
    if (v > 959) return 959;
    return v;
  endfunction

  bit [3:0]    m_alive;
  int          m_kills, m_rr, m_fc, m_slot;
  logic [15:0] m_lfsr;
  int          cyc = 0;
  int          m_spawn_at = -1;
  int          m_busy = -1;
  int          m_due_T = -1;
  bit          m_on = 1'b0;

  // Decide where the attempt that becomes due in cycle t lands.
  task automatic plan(input int t);
    bit found;
    found = 1'b0;
    m_due_T = t;
    m_spawn_at = -1;
    m_busy = t + NS;
    for (int k = 0; k < NS; k++) begin
      if (!found && !m_alive[(m_rr + k) % NS]) begin
        found = 1'b1;
        m_slot = (m_rr + k) % NS;
        m_spawn_at = t + 2 + k;
        m_busy = m_spawn_at;
      end
    end
  endtask

  // Model update from the inputs seen during the cycle that just ended.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_alive = 4'b0000; m_kills = 0; m_rr = 0; m_fc = 0;
      m_lfsr = 16'hACE1; m_spawn_at = -1; m_busy = -1;
    end else begin
      if (!game_en) begin
        m_alive = 4'b0000; m_fc = 0; m_spawn_at = -1; m_busy = -1;
      end else begin
        if (hit_valid && m_alive[hit_idx]) begin
          m_alive[hit_idx] = 1'b0;
          if (m_kills < 65535) m_kills++;
        end
        if (cyc == m_spawn_at) begin
          m_alive[m_slot] = 1'b1;
          m_rr = (m_slot + 1) % NS;
          m_lfsr = ref_lfsr_next(m_lfsr);
        end
        if (vs_neg) begin
          if (m_fc == 59) begin
            m_fc = 0;
            plan(cyc + 1);
          end else begin
            m_fc++;
          end
        end
      end
      cyc++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_on && !rst) begin
      chk("m_pulse", spawn_pulse, cyc == m_spawn_at);
      chk("m_alive", alive, m_alive);
      chk("m_kills", kill_count, m_kills);
      if (cyc == m_spawn_at) begin
        chk("m_idx", spawn_idx, m_slot);
        chk("m_x", spawn_x, ref_x(m_lfsr));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic h, input logic [1:0] hi);
    vs_neg = v; hit_valid = h; hit_idx = hi;
    @(posedge clk); #1;
    vs_neg = 1'b0; hit_valid = 1'b0;
  endtask

  task automatic run_to_due();
    int n;
    n = 60 - m_fc;
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 2'd0);
  endtask

  task automatic wait_spawn(input int exp_idx, input int exp_lat, input int exp_x);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!spawn_pulse && n < 40);
    chk("spawn_seen", spawn_pulse, 1);
    chk("spawn_idx", spawn_idx, exp_idx);
    chk("spawn_lat", cyc - m_due_T, exp_lat);
    if (exp_x >= 0) chk("spawn_x", spawn_x, exp_x);
    @(posedge clk); #1;
  endtask

  task automatic no_spawn(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("no_pulse", spawn_pulse, 0);
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [15:0] lfsr;
    logic [10:0] x;
  } clamp_vec_t;
  clamp_vec_t tv[8];

  initial begin
    bit can_hit;
    int n;
    tv[0] = '{16'h0010, 11'd64};
    tv[1] = '{16'h03F0, 11'd959};
    tv[2] = '{16'h0040, 11'd64};
    tv[3] = '{16'h003F, 11'd64};
    tv[4] = '{16'h03BF, 11'd959};
    tv[5] = '{16'h03C0, 11'd959};
    tv[6] = '{16'hFD23, 11'd291};
    tv[7] = '{16'h02A5, 11'd677};

    rst = 1'b1; vs_neg = 1'b0; game_en = 1'b0; hit_valid = 1'b0; hit_idx = 2'd0;
    #12;
    chk("rst_alive", alive, 0);
    chk("rst_pulse", spawn_pulse, 0);
    chk("rst_idx", spawn_idx, 0);
    chk("rst_x", spawn_x, 0);
    chk("rst_kills", kill_count, 0);
    chk("rst_lfsr", u_dut.u_lfsr.value, 16'hACE1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    m_on = 1'b1;
    game_en = 1'b1;

    // First spawn after 60 frames: slot 0, x from the seed.
    run_to_due();
    wait_spawn(0, 2, 225);
    chk("alive_first", alive, 4'b0001);

    // Fill the rest of the pool.
    for (int s = 1; s < NS; s++) begin
      run_to_due();
      wait_spawn(s, 2, -1);
    end
    chk("alive_full", alive, 4'b1111);

    // Pool full: a full scan, no spawn.
    run_to_due();
    no_spawn(8);
    chk("alive_full_hold", alive, 4'b1111);
    chk("rr_full_scan", u_dut.rr_ptr_q, 0);

    // Free slot 2, spawn scans past 0 and 1.
    drive(1'b0, 1'b1, 2'd2);
    chk("hit2_alive", alive, 4'b1011);
    run_to_due();
    wait_spawn(2, 4, -1);
    chk("rr_after_2", u_dut.rr_ptr_q, 3);

    // alive=1011 with rr_ptr=3: slots 3,0,1 occupied, lands in 2.
    drive(1'b0, 1'b1, 2'd2);
    chk("rr_setup", u_dut.rr_ptr_q, 3);
    run_to_due();
    wait_spawn(2, 5, -1);
    chk("rr_after_wrap", u_dut.rr_ptr_q, 3);

    // Hit on a live slot then the same hit again.
    drive(1'b0, 1'b1, 2'd1);
    chk("hit1_alive", alive, 4'b1101);
    chk("hit1_kills", kill_count, 3);
    drive(1'b0, 1'b1, 2'd1);
    chk("hit1_again_kills", kill_count, 3);

    // game_en dropped while scanning.
    run_to_due();
    drive(1'b0, 1'b0, 2'd0);
    chk("drop_in_scan", u_dut.state_q, ST_SCAN);
    game_en = 1'b0;
    @(posedge clk); #1;
    chk("drop_idle", u_dut.state_q, ST_IDLE);
    chk("drop_alive", alive, 0);
    chk("drop_kills", kill_count, 3);
    no_spawn(6);
    game_en = 1'b1;

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      can_hit = (cyc > m_busy) || (cyc == m_spawn_at);
      if (cyc > m_busy) begin
        if (game_en && $urandom_range(0, 299) == 0) game_en = 1'b0;
        else if (!game_en && $urandom_range(0, 9) == 0) game_en = 1'b1;
      end
      drive($urandom_range(0, 3) != 0, can_hit && ($urandom_range(0, 5) == 0),
            2'($urandom_range(0, 3)));
    end
    game_en = 1'b1;
    drive(1'b0, 1'b0, 2'd0);

    // Clamp table with the LFSR forced.
    m_on = 1'b0;
    for (int i = 0; i < 8; i++) begin
      game_en = 1'b0;
      drive(1'b0, 1'b0, 2'd0);
      game_en = 1'b1;
      drive(1'b0, 1'b0, 2'd0);
      force u_dut.u_lfsr.lfsr_q = tv[i].lfsr;
      run_to_due();
      wait_spawn(m_slot, m_spawn_at - m_due_T, int'(tv[i].x));
      release u_dut.u_lfsr.lfsr_q;
    end

    // Asynchronous reset in the middle of a SPAWN cycle.
    drive(1'b0, 1'b1, 2'(m_slot));
    run_to_due();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!spawn_pulse && n < 40);
    chk("pre_rst_pulse", spawn_pulse, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_alive", alive, 0);
    chk("arst_pulse", spawn_pulse, 0);
    chk("arst_idx", spawn_idx, 0);
    chk("arst_x", spawn_x, 0);
    chk("arst_kills", kill_count, 0);
    chk("arst_state", u_dut.state_q, ST_IDLE);
    chk("arst_rr", u_dut.rr_ptr_q, 0);
    chk("arst_lfsr", u_dut.u_lfsr.value, 16'hACE1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    m_on = 1'b1;
    run_to_due();
    wait_spawn(0, 2, 225);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
